// File: rtl/gpu_fill_engine_if.sv
// Memory request bus between the fill engine and the DDR arbiter.
// The engine drives one 32-byte write command per FIFO head entry; the arbiter back-pressures with busy.
interface gpu_fill_engine_if;
  logic         o_command;
  logic         i_busy;
  logic [1:0]   o_commandSize;
  logic         o_write;
  logic [14:0]  o_adr;
  logic [2:0]   o_subadr;
  logic [15:0]  o_writeMask;
  logic [255:0] o_dataOut;

  modport master (
    output o_command, o_commandSize, o_write, o_adr, o_subadr, o_writeMask, o_dataOut,
    input  i_busy
  );

  modport slave (
    input  o_command, o_commandSize, o_write, o_adr, o_subadr, o_writeMask, o_dataOut,
    output i_busy
  );
endinterface

// File: rtl/gpu_fill_engine.sv
// VRAM rectangle fill: walks the rectangle in 16-pixel blocks, queues masked block writes
// in a small request FIFO towards the DDR arbiter and mirrors each write into the stencil cache.
module gpu_fill_engine #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FIFO_ADDR_W = 2,
  parameter int EDGE_MASK   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_InterlaceRender,
  input  logic               GPU_REG_CurrentInterlaceField,
  input  logic [8:0]         RegR0,
  input  logic [8:0]         RegG0,
  input  logic [8:0]         RegB0,
  input  logic signed [11:0] RegX0,
  input  logic signed [11:0] RegY0,
  input  logic [10:0]        RegSizeW,
  input  logic [9:0]         RegSizeH,
  input  logic               i_activateFILL,
  input  logic               i_abort,
  output logic               o_FILLInactiveNextCycle,
  output logic               o_active,
  output logic               o_stencilWriteSig,
  output logic               o_stencilReadSig,
  output logic               o_stencilFullMode,
  output logic [15:0]        o_stencilWriteValue16,
  output logic [15:0]        o_stencilWriteMask16,
  output logic [14:0]        o_stencilWriteAdr,
  gpu_fill_engine_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_LINE, S_DRAIN} state_t;

  typedef struct packed {
    logic [14:0] adr;
    logic [15:0] mask;
  } fill_req_t;

  localparam int CW = FIFO_ADDR_W + 1;

  state_t state, state_nxt;

  logic [6:0]  x_cnt;
  logic [10:0] pixel_y;
  logic [10:0] y_next;
  logic [10:0] full_size;
  logic [6:0]  n_blocks_m1;
  logic        first_blk, last_blk;
  logic [3:0]  x_lo, x_hi;
  logic [5:0]  block_x;
  logic [8:0]  scr_y;
  logic [15:0] first_m, last_m, blk_mask;
  fill_req_t   cur_req, head_req;

  logic [CW-1:0]          fifo_cnt;
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  fill_req_t              fifo_mem [FIFO_DEPTH];
  logic                   cmd_vld, full, pop, push;
  logic [15:0]            pix;

  // Block geometry of the block the x counter currently points at.
  assign full_size   = RegSizeW + {7'd0, RegX0[3:0]};
  assign n_blocks_m1 = full_size[10:4] - {6'd0, (full_size[3:0] == 4'd0)};
  assign first_blk   = (x_cnt == 7'd0);
  assign last_blk    = (x_cnt == n_blocks_m1);
  assign x_lo        = RegX0[3:0];
  assign x_hi        = RegX0[3:0] + RegSizeW[3:0] - 4'd1;
  assign block_x     = x_cnt[5:0] + RegX0[9:4];
  assign scr_y       = pixel_y[8:0] + RegY0[8:0];
  assign y_next      = pixel_y + (i_InterlaceRender ? 11'd2 : 11'd1);

  assign first_m  = 16'hFFFF << x_lo;
  assign last_m   = 16'hFFFF >> (4'd15 - x_hi);
  assign blk_mask = (EDGE_MASK != 0) ? ((first_blk ? first_m : 16'hFFFF) & (last_blk ? last_m : 16'hFFFF))
                                     : 16'hFFFF;

  assign cur_req.adr  = {scr_y, block_x};
  assign cur_req.mask = blk_mask;

  // Request FIFO; a full FIFO still accepts when the head leaves in the same cycle.
  assign cmd_vld = (fifo_cnt != '0);
  assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop     = cmd_vld && !mem.i_busy;
  assign push    = (state == S_LINE) && !i_abort && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= cur_req;
  end

  assign head_req = fifo_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_activateFILL) state_nxt = S_START;
      S_START: state_nxt = (RegSizeW == 11'd0 || RegSizeH == 10'd0) ? S_IDLE : S_LINE;
      S_LINE:  if (push && last_blk && (y_next >= {1'b0, RegSizeH})) state_nxt = S_DRAIN;
      S_DRAIN: if (!cmd_vld) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_abort) state_nxt = S_IDLE;
  end

  // Interlaced fills start on the line whose parity matches the field being rendered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_cnt   <= '0;
      pixel_y <= '0;
    end else if (state == S_START) begin
      x_cnt   <= '0;
      pixel_y <= i_InterlaceRender ? {10'd0, RegY0[0] ^ GPU_REG_CurrentInterlaceField} : 11'd0;
    end else if (push) begin
      if (last_blk) begin
        x_cnt   <= '0;
        pixel_y <= y_next;
      end else begin
        x_cnt   <= x_cnt + 7'd1;
      end
    end
  end

  assign o_active                = (state != S_IDLE);
  assign o_FILLInactiveNextCycle = o_active && (state_nxt == S_IDLE);

  assign o_stencilWriteSig     = push;
  assign o_stencilReadSig      = 1'b0;
  assign o_stencilFullMode     = 1'b1;
  assign o_stencilWriteValue16 = 16'd0;
  assign o_stencilWriteMask16  = push ? cur_req.mask : 16'd0;
  assign o_stencilWriteAdr     = push ? cur_req.adr  : 15'd0;

  assign mem.o_command     = cmd_vld;
  assign mem.o_commandSize = 2'd1;
  assign mem.o_write       = 1'b1;
  assign mem.o_subadr      = 3'd0;
  assign mem.o_adr         = cmd_vld ? head_req.adr  : 15'd0;
  assign mem.o_writeMask   = cmd_vld ? head_req.mask : 16'd0;

  assign pix = {1'b0, RegB0[7:3], RegG0[7:3], RegR0[7:3]};

  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign mem.o_dataOut[i*16 +: 16] = cmd_vld ? pix : 16'd0;
  end

  logic unused_bits;
  assign unused_bits = ^{RegR0[8], RegR0[2:0], RegG0[8], RegG0[2:0], RegB0[8], RegB0[2:0],
                         RegX0[11:10], RegY0[11:9]};

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Bench for gpu_fill_engine: a pixel-level model fills per-DUT scoreboards that are drained
// by monitors on the command bus and the stencil strobe.
module tb_gpu_fill_engine;

  typedef struct packed {
    logic [14:0] adr;
    logic [15:0] mask;
  } req_t;

  typedef struct {
    int                d;
    logic signed [11:0] x0, y0;
    logic [10:0]       w;
    logic [9:0]        h;
    logic              il, fld;
    logic [8:0]        r, g, b;
    int                ncmd;
  } vec_t;

  logic clk = 0;
  logic rst = 1;
  logic il = 0, fld = 0;
  logic [8:0] r = 0, g = 0, b = 0;
  logic signed [11:0] x0 = 0, y0 = 0;
  logic [10:0] w = 0;
  logic [9:0]  h = 0;
  logic [1:0]  act = 0, abt = 0;

  logic [1:0]  inact, active, ssig, srd, sfull;
  logic [15:0] sval [2];
  logic [15:0] smsk [2];
  logic [14:0] sadr [2];

  int errors = 0, checks = 0;
  int ncmd [2];
  int nstb [2];
  int npls [2];

  req_t exp_c0[$], exp_c1[$], exp_s0[$], exp_s1[$];

  gpu_fill_engine_if m0 ();
  gpu_fill_engine_if m1 ();

  always #5 clk = ~clk;

  gpu_fill_engine #(.FIFO_DEPTH(4), .FIFO_ADDR_W(2), .EDGE_MASK(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_InterlaceRender(il), .GPU_REG_CurrentInterlaceField(fld),
    .RegR0(r), .RegG0(g), .RegB0(b), .RegX0(x0), .RegY0(y0), .RegSizeW(w), .RegSizeH(h),
    .i_activateFILL(act[0]), .i_abort(abt[0]),
    .o_FILLInactiveNextCycle(inact[0]), .o_active(active[0]),
    .o_stencilWriteSig(ssig[0]), .o_stencilReadSig(srd[0]), .o_stencilFullMode(sfull[0]),
    .o_stencilWriteValue16(sval[0]), .o_stencilWriteMask16(smsk[0]), .o_stencilWriteAdr(sadr[0]),
    .mem(m0));

  gpu_fill_engine #(.FIFO_DEPTH(2), .FIFO_ADDR_W(1), .EDGE_MASK(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_InterlaceRender(il), .GPU_REG_CurrentInterlaceField(fld),
    .RegR0(r), .RegG0(g), .RegB0(b), .RegX0(x0), .RegY0(y0), .RegSizeW(w), .RegSizeH(h),
    .i_activateFILL(act[1]), .i_abort(abt[1]),
    .o_FILLInactiveNextCycle(inact[1]), .o_active(active[1]),
    .o_stencilWriteSig(ssig[1]), .o_stencilReadSig(srd[1]), .o_stencilFullMode(sfull[1]),
    .o_stencilWriteValue16(sval[1]), .o_stencilWriteMask16(smsk[1]), .o_stencilWriteAdr(sadr[1]),
    .mem(m1));

  task automatic chk(input string name, input logic [255:0] actual, input logic [255:0] expv);
    checks++;
    if (actual !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expv);
    end
  endtask

  function automatic logic [255:0] exp_data();
    logic [15:0] p;
    p = {1'b0, b[7:3], g[7:3], r[7:3]};
    return {16{p}};
  endfunction

  // Pixel-level model: every covered pixel sets its bit in the block it falls into.
  task automatic build(input int d, input logic legacy);
    int py, ys, step, xs, blk, prev;
    logic [15:0] m;
    logic [8:0] sy;
    req_t e;
    if (w == 0 || h == 0) return;
    ys   = il ? int'(y0[0] ^ fld) : 0;
    step = il ? 2 : 1;
    xs   = int'(x0);
    py   = ys;
    do begin
      sy = 9'((py + int'(y0)) & 511);
      prev = -1;
      m = 0;
      for (int px = xs; px < xs + int'(w); px++) begin
        blk = (px >>> 4) & 63;
        if (blk != prev && prev != -1) begin
          e.adr = {sy, 6'(prev)}; e.mask = legacy ? 16'hFFFF : m;
          if (d == 0) begin exp_c0.push_back(e); exp_s0.push_back(e); end
          else        begin exp_c1.push_back(e); exp_s1.push_back(e); end
          m = 0;
        end
        prev = blk;
        m[px & 15] = 1'b1;
      end
      e.adr = {sy, 6'(prev)}; e.mask = legacy ? 16'hFFFF : m;
      if (d == 0) begin exp_c0.push_back(e); exp_s0.push_back(e); end
      else        begin exp_c1.push_back(e); exp_s1.push_back(e); end
      py += step;
    end while (py < int'(h));
  endtask

  task automatic mon(input int d, input logic cmd, input logic busy, input logic [14:0] adr,
                     input logic [15:0] msk, input logic [255:0] dat, input logic ss,
                     input logic [14:0] sa, input logic [15:0] sm, input logic ina);
    req_t e;
    if (cmd && !busy) begin
      ncmd[d]++;
      if ((d == 0 ? exp_c0.size() : exp_c1.size()) == 0) begin
        chk("unexpected_cmd", {241'd0, adr}, 256'd0);
      end else begin
        e = (d == 0) ? exp_c0.pop_front() : exp_c1.pop_front();
        chk("cmd_adr", {241'd0, adr}, {241'd0, e.adr});
        chk("cmd_mask", {240'd0, msk}, {240'd0, e.mask});
        chk("cmd_data", dat, exp_data());
      end
    end
    if (ss) begin
      nstb[d]++;
      if ((d == 0 ? exp_s0.size() : exp_s1.size()) == 0) begin
        chk("unexpected_stencil", {241'd0, sa}, 256'd0);
      end else begin
        e = (d == 0) ? exp_s0.pop_front() : exp_s1.pop_front();
        chk("stencil_adr", {241'd0, sa}, {241'd0, e.adr});
        chk("stencil_mask", {240'd0, sm}, {240'd0, e.mask});
      end
    end
    if (ina) npls[d]++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, m0.o_command, m0.i_busy, m0.o_adr, m0.o_writeMask, m0.o_dataOut, ssig[0], sadr[0], smsk[0], inact[0]);
      mon(1, m1.o_command, m1.i_busy, m1.o_adr, m1.o_writeMask, m1.o_dataOut, ssig[1], sadr[1], smsk[1], inact[1]);
    end
  end

  task automatic pulse_act(input int d);
    @(posedge clk); #1 act[d] = 1'b1;
    @(posedge clk); #1 act[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    while (active[d] && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 256'd1, 256'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int c0, p0;
    x0 = v.x0; y0 = v.y0; w = v.w; h = v.h; il = v.il; fld = v.fld;
    r = v.r; g = v.g; b = v.b;
    build(v.d, v.d == 1);
    c0 = ncmd[v.d]; p0 = npls[v.d];
    pulse_act(v.d);
    wait_idle(v.d);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_ncmd"}, 256'(ncmd[v.d] - c0), 256'(v.ncmd));
    chk({name, "_leftover"}, 256'(v.d == 0 ? exp_c0.size() + exp_s0.size() : exp_c1.size() + exp_s1.size()), 256'd0);
    chk({name, "_inact_pulse"}, 256'(npls[v.d] - p0), 256'd1);
  endtask

  vec_t tbl [7];

  initial begin
    int c0, s0, p0;
    tbl[0] = '{0, 12'sh013, 12'sh010, 11'h20, 10'd1,  1'b0, 1'b0, 9'hFF, 9'h00, 9'h00, 3};
    tbl[1] = '{1, 12'sh013, 12'sh010, 11'h20, 10'd1,  1'b0, 1'b0, 9'hFF, 9'h00, 9'h00, 3};
    tbl[2] = '{0, 12'sh3F8, 12'sh000, 11'd16, 10'd1,  1'b0, 1'b0, 9'h00, 9'hFF, 9'h80, 2};
    tbl[3] = '{0, 12'sh000, 12'sh004, 11'd16, 10'd4,  1'b1, 1'b1, 9'h38, 9'h50, 9'h18, 2};
    tbl[4] = '{0, 12'sh000, 12'sh000, 11'd0,  10'd5,  1'b0, 1'b0, 9'hFF, 9'hFF, 9'hFF, 0};
    tbl[5] = '{0, -12'sd3,  12'sh1F8, 11'd40, 10'd10, 1'b0, 1'b0, 9'h10, 9'h20, 9'h40, 40};
    tbl[6] = '{0, 12'sh005, 12'sh020, 11'd1,  10'd1,  1'b0, 1'b0, 9'hA8, 9'h08, 9'hF0, 1};
    m0.i_busy = 0; m1.i_busy = 0;
    for (int i = 0; i < 2; i++) begin ncmd[i] = 0; nstb[i] = 0; npls[i] = 0; end

    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_active", {254'd0, active}, 256'd0);
    chk("rst_cmd", {254'd0, m1.o_command, m0.o_command}, 256'd0);
    chk("rst_adr", {226'd0, m1.o_adr, m0.o_adr}, 256'd0);
    chk("rst_wmask", {224'd0, m1.o_writeMask, m0.o_writeMask}, 256'd0);
    chk("rst_data", m0.o_dataOut, 256'd0);
    chk("rst_stencil_sig", {254'd0, ssig}, 256'd0);
    chk("const_fields", {245'd0, sfull, srd, m0.o_commandSize, m0.o_write, m0.o_subadr},
        {245'd0, 2'b11, 2'b00, 2'd1, 1'b1, 3'd0});

    // Hand-derived reference for the first vector's model output.
    x0 = tbl[0].x0; w = tbl[0].w; h = tbl[0].h; y0 = tbl[0].y0; il = 0;
    build(0, 1'b0);
    chk("model_blk0", {225'd0, exp_c0[0]}, {225'd0, 15'({9'h010, 6'd1}), 16'hFFF8});
    chk("model_blk2", {225'd0, exp_c0[2]}, {225'd0, 15'({9'h010, 6'd3}), 16'h0007});
    exp_c0.delete(); exp_s0.delete();

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure on the 2-deep FIFO: two blocks accepted, engine stalls in LINE.
    x0 = 0; y0 = 12'sh030; w = 11'd64; h = 10'd1; il = 0; r = 9'h08; g = 9'h10; b = 9'h20;
    m1.i_busy = 1;
    build(1, 1'b1);
    c0 = ncmd[1]; s0 = nstb[1]; p0 = npls[1];
    pulse_act(1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_accepted", 256'(nstb[1] - s0), 256'd2);
    chk("busy_active", {255'd0, active[1]}, 256'd1);
    chk("busy_cmd", {255'd0, m1.o_command}, 256'd1);
    m1.i_busy = 0;
    wait_idle(1);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_ncmd", 256'(ncmd[1] - c0), 256'd4);
    chk("busy_inact_pulse", 256'(npls[1] - p0), 256'd1);
    chk("busy_leftover", 256'(exp_c1.size() + exp_s1.size()), 256'd0);

    // Abort with a full FIFO: flushed in one cycle, nothing further reaches the bus.
    m1.i_busy = 1;
    build(1, 1'b1);
    c0 = ncmd[1];
    pulse_act(1);
    repeat (8) @(posedge clk);
    #1 abt[1] = 1'b1;
    @(posedge clk); #1 abt[1] = 1'b0;
    chk("abort_active", {255'd0, active[1]}, 256'd0);
    chk("abort_cmd", {255'd0, m1.o_command}, 256'd0);
    exp_c1.delete(); exp_s1.delete();
    m1.i_busy = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_cmd", 256'(ncmd[1] - c0), 256'd0);
    run_vec(tbl[1], "after_abort");

    // Abort wins over a simultaneous activate.
    @(posedge clk); #1 act[0] = 1'b1; abt[0] = 1'b1;
    @(posedge clk); #1 act[0] = 1'b0; abt[0] = 1'b0;
    chk("abort_over_act", {255'd0, active[0]}, 256'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
